sc_buffer_serializer: RTL and testbench
=======================================

# sc_buffer_serializer

Collects per-lane note-match events from the 37 parallel note-lane comparators and serializes them onto a single match stream for the scoring logic. Each lane event carries a 16-bit scheduled note time. The block captures the timing error (song time minus note time) at the moment of the event and buffers one pending entry per lane. It then emits the entries one per clock with a lowest-lane-first priority.

## Interface
- No parameters; the lane count is fixed at 37 and the time width at 16 bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- song_time  input  16  current song time, unsigned, monotonically increasing with wrap-around.
- match_trigger  input  37  one-cycle pulse per lane; bit i marks a match on lane i.
- match_time  input  37*16  packed scheduled note times; lane i is bits [16*i+15:16*i]. Sampled only when trigger bit i is high.
- match_en  output  1  one-cycle strobe: match_dt is valid.
- match_dt  output  16  timing error of the emitted entry.
- queue  output  16  number of lanes currently pending, zero-extended (0..37).

## Operation
- Per-lane state: pending bit p[i] and a 16-bit stored error d[i].
- Capture: on an edge where match_trigger[i]=1, set p[i]=1 and d[i]=song_time-match_time[i] (mod 2^16, two's complement).
- Re-trigger of an already pending lane overwrites d[i]. No second entry is created.
- Arbitration: each edge, if any p[i]=1 at the start of the cycle, select the lowest such i.
  - Register match_en=1 and match_dt=d[i].
  - Clear p[i].
- If nothing is pending, match_en=0 and match_dt holds its last value.
- Simultaneous clear and capture on the same lane in the same edge: the capture wins. p[i] stays 1 with the new d[i], and the old d[i] is the one emitted.
- Multiple lanes triggering in one cycle are all captured. They are emitted on consecutive cycles in ascending lane order.
- queue is the registered population count of p after the edge's clear and set updates.
- No backpressure: the consumer must accept one entry per cycle.

## Timing
- Reset (asynchronous assert, synchronous release): p=0, d=0, match_en=0, match_dt=0, queue=0.
- Latency: a trigger sampled at edge k sets p at edge k. match_en is high for the cycle following edge k+1 (2 edges, trigger to strobe), provided no lower lane is pending.
- match_dt uses the song_time sampled at the capture edge k, not at emission.
- queue rises at edge k and falls at edge k+1 when the entry is emitted.
- Worst-case drain: 37 cycles for all lanes pending.
- Reset asserted mid-drain discards all pending entries immediately. No partial emission.

## Configuration
- SC_SER_ABS_DT_EN
  - Defined: match_dt outputs the magnitude |song_time-match_time|, computed as the two's-complement absolute value of the stored difference. The value 0x8000 saturates to 0x7FFF.
  - Undefined: match_dt is the raw signed difference.

## Test plan
- Reset: hold rst_n=0 with random triggers -> match_en=0, match_dt=0, queue=0. After release, queue stays 0 with no triggers.
- Single lane: song_time=11, pulse match_trigger=1 with match_time[15:0]=7 for one cycle -> queue=1 after that edge. Next cycle match_en=1, match_dt=4, queue=0. match_en is low afterwards.
- Late/early sign: song_time=5, lane 3 with time 9 -> match_dt=0xFFFC. With SC_SER_ABS_DT_EN defined -> match_dt=4.
- Burst: lanes 36, 0 and 10 in the same cycle with times giving errors 1, 2 and 3 -> queue=3, then three consecutive strobes. Order is lane 0 (2), lane 10 (3), lane 36 (1). queue steps 2,1,0.
- Collision: lane 5 pending with error 8 and lane 5 retriggered (error 2) on its emission edge -> emits 8. Next cycle emits 2. queue stays 1 for one extra cycle.
- Mid-drain reset: all 37 lanes triggered, rst_n pulsed low after 10 strobes -> outputs zero immediately and no further strobes.

Source files
------------

// File: rtl/sc_buffer_serializer.sv
// Buffers one pending note-match entry per lane and drains them lowest-lane-first, one per clock.
// Optional SC_SER_ABS_DT_EN: emit |song_time - match_time| (0x8000 saturates to 0x7FFF) instead of the signed error.
module sc_buffer_serializer (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    song_time,
    input  logic [36:0]    match_trigger,
    input  logic [37*16-1:0] match_time,
    output logic           match_en,
    output logic [15:0]    match_dt,
    output logic [15:0]    queue
);

    localparam int unsigned LANES = 37;

    logic [LANES-1:0] p_q, p_d;
    logic [15:0]      d_q [LANES];
    logic [15:0]      d_d [LANES];
    logic             en_q, en_d;
    logic [15:0]      dt_q, dt_d;
    logic [15:0]      queue_q, queue_d;

    logic [LANES-1:0] sel;
    logic [15:0]      sel_dt;

    function automatic logic [15:0] dt_view(input logic [15:0] diff);
`ifdef SC_SER_ABS_DT_EN
        logic [15:0] mag;
        mag = diff[15] ? (16'd0 - diff) : diff;
        return (mag == 16'h8000) ? 16'h7FFF : mag;
`else
        return diff;
`endif
    endfunction

    always_comb begin
        // Isolate the lowest set pending bit.
        sel     = p_q & (~p_q + 37'd1);
        sel_dt  = '0;
        p_d     = (p_q & ~sel) | match_trigger;
        queue_d = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (sel[i]) sel_dt = sel_dt | d_q[i];
            d_d[i]  = match_trigger[i] ? (song_time - match_time[16*i +: 16]) : d_q[i];
            queue_d = queue_d + 16'(p_d[i]);
        end
        en_d = |p_q;
        dt_d = en_d ? dt_view(sel_dt) : dt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            d_q     <= '{default: '0};
            en_q    <= 1'b0;
            dt_q    <= '0;
            queue_q <= '0;
        end else begin
            p_q     <= p_d;
            d_q     <= d_d;
            en_q    <= en_d;
            dt_q    <= dt_d;
            queue_q <= queue_d;
        end
    end

    assign match_en = en_q;
    assign match_dt = dt_q;
    assign queue    = queue_q;

endmodule

// File: tb/tb_sc_buffer_serializer.sv
// Randomized and directed bench for sc_buffer_serializer against a per-lane array model.
module tb_sc_buffer_serializer;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [15:0]    song_time;
    logic [36:0]    match_trigger;
    logic [591:0]   match_time;
    logic           match_en;
    logic [15:0]    match_dt;
    logic [15:0]    queue;

    int checks = 0;
    int errors = 0;

    bit          mp [37];
    logic [15:0] md [37];
    logic        exp_en;
    logic [15:0] exp_dt;
    logic [15:0] exp_q;

    sc_buffer_serializer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .song_time    (song_time),
        .match_trigger(match_trigger),
        .match_time   (match_time),
        .match_en     (match_en),
        .match_dt     (match_dt),
        .queue        (queue)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] view(input logic [15:0] diff);
`ifdef SC_SER_ABS_DT_EN
        int v;
        v = int'($signed(diff));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
`else
        return diff;
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 37; i++) begin
            mp[i] = 0;
            md[i] = '0;
        end
        exp_en = 1'b0;
        exp_dt = '0;
        exp_q  = '0;
    endfunction

    task automatic tick();
        int found;
        int cnt;
        @(posedge clk);
        if (rst_n) begin
            found = -1;
            for (int i = 0; i < 37; i++)
                if (mp[i] && found < 0) found = i;
            exp_en = (found >= 0);
            if (found >= 0) begin
                exp_dt = view(md[found]);
                mp[found] = 0;
            end
            for (int i = 0; i < 37; i++)
                if (match_trigger[i]) begin
                    mp[i] = 1;
                    md[i] = song_time - match_time[16*i +: 16];
                end
            cnt = 0;
            for (int i = 0; i < 37; i++) cnt += int'(mp[i]);
            exp_q = 16'(cnt);
        end
        #1;
    endtask

    task automatic clear_inputs();
        match_trigger = '0;
        match_time    = '0;
    endtask

    task automatic random_triggers(input int density);
        for (int i = 0; i < 37; i++) begin
            match_trigger[i]       = ($urandom_range(density - 1) == 0);
            match_time[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        song_time = 16'd0;
        model_reset();
        for (int c = 0; c < 4; c++) begin
            random_triggers(2);
            song_time = 16'($urandom);
            tick();
            checks++;
            if (match_en !== 1'b0 || match_dt !== 16'd0 || queue !== 16'd0) begin
                errors++;
                $display("FAIL reset_hold: en=%b dt=%h q=%0d want 0/0000/0", match_en, match_dt, queue);
            end
        end
        clear_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (match_en !== 1'b0 || queue !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle: en=%b q=%0d want 0/0", match_en, queue);
            end
        end
    endtask

    task automatic test_single();
        song_time = 16'd11;
        match_trigger = 37'd1;
        match_time[15:0] = 16'd7;
        tick();
        checks++;
        if (queue !== 16'd1 || match_en !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: q=%0d en=%b want 1/0", queue, match_en);
        end
        clear_inputs();
        tick();
        checks++;
        if (match_en !== 1'b1 || match_dt !== 16'd4 || queue !== 16'd0) begin
            errors++;
            $display("FAIL single_emit: en=%b dt=%h q=%0d want 1/0004/0", match_en, match_dt, queue);
        end
        tick();
        checks++;
        if (match_en !== 1'b0 || match_dt !== 16'd4) begin
            errors++;
            $display("FAIL single_after: en=%b dt=%h want 0/0004", match_en, match_dt);
        end
    endtask

    task automatic test_sign();
        logic [15:0] want;
`ifdef SC_SER_ABS_DT_EN
        want = 16'd4;
`else
        want = 16'hFFFC;
`endif
        song_time = 16'd5;
        match_trigger = 37'd1 << 3;
        match_time[16*3 +: 16] = 16'd9;
        tick();
        clear_inputs();
        tick();
        checks++;
        if (match_en !== 1'b1 || match_dt !== want) begin
            errors++;
            $display("FAIL sign: en=%b dt=%h want 1/%h", match_en, match_dt, want);
        end
    endtask

    task automatic test_burst();
        logic [15:0] wdt [3];
        logic [15:0] wq [3];
        wdt = '{16'd2, 16'd3, 16'd1};
        wq  = '{16'd2, 16'd1, 16'd0};
        song_time = 16'd100;
        match_trigger = (37'd1 << 36) | 37'd1 | (37'd1 << 10);
        match_time[16*36 +: 16] = 16'd99;
        match_time[15:0]        = 16'd98;
        match_time[16*10 +: 16] = 16'd97;
        tick();
        checks++;
        if (queue !== 16'd3) begin
            errors++;
            $display("FAIL burst_queue: q=%0d want 3", queue);
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (match_en !== 1'b1 || match_dt !== wdt[k] || queue !== wq[k]) begin
                errors++;
                $display("FAIL burst_%0d: en=%b dt=%h q=%0d want 1/%h/%0d", k, match_en, match_dt, queue, wdt[k], wq[k]);
            end
        end
    endtask

    task automatic test_collision();
        song_time = 16'd50;
        match_trigger = 37'd1 << 5;
        match_time[16*5 +: 16] = 16'd42;
        tick();
        match_time[16*5 +: 16] = 16'd48;
        tick();
        checks++;
        if (match_en !== 1'b1 || match_dt !== 16'd8 || queue !== 16'd1) begin
            errors++;
            $display("FAIL collision_first: en=%b dt=%h q=%0d want 1/0008/1", match_en, match_dt, queue);
        end
        clear_inputs();
        tick();
        checks++;
        if (match_en !== 1'b1 || match_dt !== 16'd2 || queue !== 16'd0) begin
            errors++;
            $display("FAIL collision_second: en=%b dt=%h q=%0d want 1/0002/0", match_en, match_dt, queue);
        end
        tick();
        checks++;
        if (match_en !== 1'b0) begin
            errors++;
            $display("FAIL collision_idle: en=%b want 0", match_en);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            random_triggers((c % 100 < 50) ? 24 : 6);
            song_time = song_time + 16'($urandom_range(1, 3000));
            tick();
            checks++;
            if (match_en !== exp_en || match_dt !== exp_dt || queue !== exp_q) begin
                errors++;
                $display("FAIL random_c%0d: en=%b dt=%h q=%0d want %b/%h/%0d", c, match_en, match_dt, queue, exp_en, exp_dt, exp_q);
            end
        end
        clear_inputs();
        for (int c = 0; c < 40; c++) begin
            tick();
            checks++;
            if (match_en !== exp_en || match_dt !== exp_dt || queue !== exp_q) begin
                errors++;
                $display("FAIL random_drain%0d: en=%b dt=%h q=%0d want %b/%h/%0d", c, match_en, match_dt, queue, exp_en, exp_dt, exp_q);
            end
        end
    endtask

    task automatic test_mid_drain_reset();
        match_trigger = '1;
        for (int i = 0; i < 37; i++) match_time[16*i +: 16] = 16'($urandom);
        song_time = 16'($urandom);
        tick();
        checks++;
        if (queue !== 16'd37) begin
            errors++;
            $display("FAIL drain_full: q=%0d want 37", queue);
        end
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (match_en !== exp_en || match_dt !== exp_dt || queue !== exp_q) begin
                errors++;
                $display("FAIL drain_%0d: en=%b dt=%h q=%0d want %b/%h/%0d", k, match_en, match_dt, queue, exp_en, exp_dt, exp_q);
            end
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (match_en !== 1'b0 || match_dt !== 16'd0 || queue !== 16'd0) begin
            errors++;
            $display("FAIL drain_async_rst: en=%b dt=%h q=%0d want 0/0000/0", match_en, match_dt, queue);
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            checks++;
            if (match_en !== 1'b0 || queue !== 16'd0) begin
                errors++;
                $display("FAIL drain_after_rst%0d: en=%b q=%0d want 0/0", c, match_en, queue);
            end
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_sign();
        test_burst();
        test_collision();
        test_random();
        test_mid_drain_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
